product_accumulator_64b: RTL and testbench

Sequential accumulator that sits directly downstream of `multiplier_32b`. It consumes that block's signed 64-bit products one per beat and sums a block of terms delimited by a `last` flag, which makes the pair a dot-product / MAC datapath. Each block result is saturated to 64 bits and held in a one-entry output register under a valid/ready handshake. Accumulation of the next block overlaps with the wait for the previous result to drain.

---
 rtl/product_accumulator_64b_if.sv | 32 +++
 rtl/product_accumulator_64b.sv | 176 +++++++++++++++++
 tb/tb_product_accumulator_64b.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_64b_if.sv
// Stream interface between a signed-product source and the block accumulator.
// The product side carries one term per beat with a last flag; the result side
// carries a saturated block sum, its term count and an overflow flag.
interface product_accumulator_64b_if #(
  parameter int PW = 64,
  parameter int CW = 16
);
  // Product stream (source -> accumulator)
  logic signed [PW-1:0] p;
  logic                 p_valid;
  logic                 p_last;
  logic                 p_ready;

  // Result stream (accumulator -> consumer)
  logic signed [PW-1:0] out_sum;
  logic [CW-1:0]        out_cnt;
  logic                 out_ovf;
  logic                 out_valid;
  logic                 out_ready;

  // Producer of products and consumer of results
  modport master (
    output p, p_valid, p_last, out_ready,
    input  p_ready, out_sum, out_cnt, out_ovf, out_valid
  );

  // The accumulator itself
  modport slave (
    input  p, p_valid, p_last, out_ready,
    output p_ready, out_sum, out_cnt, out_ovf, out_valid
  );
endinterface

// File: rtl/product_accumulator_64b.sv
// Block accumulator for signed products. Terms are summed in a wide
// accumulator until a beat flagged last arrives; the block total is then
// saturated to PW bits and parked in a one-entry result register guarded by a
// valid/ready handshake. The next block accumulates while the result waits.
module product_accumulator_64b #(
  parameter int PW = 64,
  parameter int AW = 80,
  parameter int CW = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  product_accumulator_64b_if.slave bus
);

  // Result register occupancy: EMPTY holds nothing, FULL holds an undrained sum.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Term counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    logic [CW-1:0] res;
    if (&c) begin
      res = c;
    end else begin
      res = c + CW'(1'b1);
    end
    return res;
  endfunction

  // The wide total fits in PW signed bits only if every bit from PW-1 upward
  // equals the sign bit; anything else means the block sum left PW range.
  function automatic logic sat_ovf(input logic [AW-1:0] t);
    logic [AW-PW:0] hi;
    hi = t[AW-1:PW-1];
    return ~((&hi) | ~(|hi));
  endfunction

  // Clamp the wide total to the most positive / most negative PW-bit value.
  function automatic logic [PW-1:0] sat_pw(input logic [AW-1:0] t);
    logic [PW-1:0] res;
    if (sat_ovf(t)) begin
      if (t[AW-1]) begin
        res = {1'b1, {(PW-1){1'b0}}};
      end else begin
        res = {1'b0, {(PW-1){1'b1}}};
      end
    end else begin
      res = t[PW-1:0];
    end
    return res;
  endfunction

  // Accumulation state
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;

  // Result register
  logic [PW-1:0] r_out_sum;
  logic [CW-1:0] r_out_cnt;
  logic          r_out_ovf;
  state_e        r_state;

  // Combinational datapath and control
  logic [AW-1:0] w_p_ext;
  logic [AW-1:0] w_sum;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_out_valid;
  logic          w_p_ready;
  logic          w_beat;
  logic          w_last_beat;
  logic          w_drain;
  logic          w_load;
  state_e        w_state_nxt;

  assign w_out_valid = (r_state == ST_FULL);

  // Back-pressure only when a full result is not being taken this cycle; the
  // same condition gates every beat so a block can never run ahead of its
  // predecessor's result.
  assign w_p_ready   = ~i_rst & (~w_out_valid | bus.out_ready);
  assign w_beat      = bus.p_valid & w_p_ready;
  assign w_last_beat = w_beat & bus.p_last;
  assign w_drain     = w_out_valid & bus.out_ready;

  // Sign-extend the product and form the running total including this term.
  assign w_p_ext   = AW'($signed(bus.p));
  assign w_sum     = r_acc + w_p_ext;
  assign w_cnt_nxt = cnt_inc(r_cnt);

  // Next occupancy of the result register and the load strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_last_beat) begin
          w_state_nxt = ST_FULL;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_last_beat) begin
          // Drain and reload on the same edge: the old result leaves, the new
          // one takes its place, occupancy stays FULL.
          w_state_nxt = ST_FULL;
          w_load      = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_load      = 1'b0;
      end
    endcase
  end

  // Result register occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Running total and term count; cleared when a block completes so the next
  // block starts on the following edge with no bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= {AW{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (w_beat) begin
      if (bus.p_last) begin
        r_acc <= {AW{1'b0}};
        r_cnt <= {CW{1'b0}};
      end else begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_nxt;
      end
    end else begin
      r_acc <= r_acc;
      r_cnt <= r_cnt;
    end
  end

  // Result payload; only written on a load so it stays stable while waiting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_sum <= {PW{1'b0}};
      r_out_cnt <= {CW{1'b0}};
      r_out_ovf <= 1'b0;
    end else if (w_load) begin
      r_out_sum <= sat_pw(w_sum);
      r_out_cnt <= w_cnt_nxt;
      r_out_ovf <= sat_ovf(w_sum);
    end else begin
      r_out_sum <= r_out_sum;
      r_out_cnt <= r_out_cnt;
      r_out_ovf <= r_out_ovf;
    end
  end

  assign bus.p_ready   = w_p_ready;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cnt   = r_out_cnt;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_valid = w_out_valid;

endmodule

// File: tb/tb_product_accumulator_64b.sv
// Self-checking bench for product_accumulator_64b: directed vector table,
// hand-written handshake sequences and a randomized scoreboard run.
module tb_product_accumulator_64b;

  localparam int PW = 64;
  localparam int CW = 16;
  localparam int NBLK = 1000;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  product_accumulator_64b_if #(.PW(PW), .CW(CW)) bus ();

  product_accumulator_64b #(.PW(PW), .AW(80), .CW(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] p;
    logic        last;
    logic        exp_valid;
    logic [63:0] exp_sum;
    logic [15:0] exp_cnt;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic [15:0] cnt;
    logic        ovf;
  } res_t;

  localparam logic signed [127:0] MAXV = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MINV = -128'sh8000_0000_0000_0000;

  vec_t tbl [11];
  res_t exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] pv, input logic lst);
    bus.p       = pv;
    bus.p_last  = lst;
    bus.p_valid = 1'b1;
    tick();
    bus.p_valid = 1'b0;
    bus.p_last  = 1'b0;
  endtask

  // Reference saturation of an exact integer block sum.
  function automatic res_t ref_result(input logic signed [127:0] s, input int n);
    res_t r;
    r.cnt = 16'(n);
    if (s > MAXV) begin
      r.sum = 64'h7FFF_FFFF_FFFF_FFFF;
      r.ovf = 1'b1;
    end else if (s < MINV) begin
      r.sum = 64'h8000_0000_0000_0000;
      r.ovf = 1'b1;
    end else begin
      r.sum = s[63:0];
      r.ovf = 1'b0;
    end
    return r;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    bus.p = 64'd0;
    bus.p_valid = 1'b0;
    bus.p_last  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;

    tbl[0]  = '{64'd1000,                 1'b0, 1'b0, 64'd0,                    16'd0, 1'b0};
    tbl[1]  = '{-64'sd250,                1'b0, 1'b0, 64'd0,                    16'd0, 1'b0};
    tbl[2]  = '{64'd7,                    1'b1, 1'b1, 64'd757,                  16'd3, 1'b0};
    tbl[3]  = '{64'd2,                    1'b1, 1'b1, 64'd2,                    16'd1, 1'b0};
    tbl[4]  = '{64'h7FFF_FFFF_FFFF_FFFF,  1'b0, 1'b0, 64'd0,                    16'd0, 1'b0};
    tbl[5]  = '{64'd1,                    1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,  16'd2, 1'b1};
    tbl[6]  = '{64'h8000_0000_0000_0000,  1'b0, 1'b0, 64'd0,                    16'd0, 1'b0};
    tbl[7]  = '{-64'sd1,                  1'b1, 1'b1, 64'h8000_0000_0000_0000,  16'd2, 1'b1};
    tbl[8]  = '{64'h7FFF_FFFF_FFFF_FFFF,  1'b0, 1'b0, 64'd0,                    16'd0, 1'b0};
    tbl[9]  = '{64'd1,                    1'b0, 1'b0, 64'd0,                    16'd0, 1'b0};
    tbl[10] = '{-64'sd1,                  1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,  16'd3, 1'b0};

    // Reset state
    tick();
    tick();
    chk("rst_p_ready", {63'd0, bus.p_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_sum", bus.out_sum, 64'd0);
    chk("rst_out_cnt", {48'd0, bus.out_cnt}, 64'd0);
    chk("rst_out_ovf", {63'd0, bus.out_ovf}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_p_ready", {63'd0, bus.p_ready}, 64'd1);

    // Single-term block
    beat(-64'sd5, 1'b1);
    chk("single_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("single_sum", bus.out_sum, -64'sd5);
    chk("single_cnt", {48'd0, bus.out_cnt}, 64'd1);
    chk("single_ovf", {63'd0, bus.out_ovf}, 64'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("single_drained", {63'd0, bus.out_valid}, 64'd0);

    // Vector table, back-to-back beats, consumer always ready
    for (int i = 0; i < 11; i++) begin
      beat(tbl[i].p, tbl[i].last);
      chk($sformatf("tbl%0d_valid", i), {63'd0, bus.out_valid}, {63'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_sum", i), bus.out_sum, tbl[i].exp_sum);
        chk($sformatf("tbl%0d_cnt", i), {48'd0, bus.out_cnt}, {48'd0, tbl[i].exp_cnt});
        chk($sformatf("tbl%0d_ovf", i), {63'd0, bus.out_ovf}, {63'd0, tbl[i].exp_ovf});
      end
    end
    tick();
    chk("tbl_drained", {63'd0, bus.out_valid}, 64'd0);

    // Backpressure
    bus.out_ready = 1'b0;
    beat(64'd10, 1'b1);
    chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
    bus.p = 64'd3;
    bus.p_last = 1'b0;
    bus.p_valid = 1'b1;
    #1;
    chk("bp_p_ready_low", {63'd0, bus.p_ready}, 64'd0);
    tick();
    chk("bp_sum_hold", bus.out_sum, 64'd10);
    chk("bp_valid_hold", {63'd0, bus.out_valid}, 64'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_p_ready_high", {63'd0, bus.p_ready}, 64'd1);
    tick();
    chk("bp_drained", {63'd0, bus.out_valid}, 64'd0);
    beat(64'd4, 1'b1);
    chk("bp_valid2", {63'd0, bus.out_valid}, 64'd1);
    chk("bp_sum", bus.out_sum, 64'd7);
    chk("bp_cnt", {48'd0, bus.out_cnt}, 64'd2);
    tick();

    // Reset mid-block
    beat(64'd100, 1'b0);
    beat(64'd200, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    beat(64'd4, 1'b1);
    chk("rstmid_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("rstmid_sum", bus.out_sum, 64'd4);
    chk("rstmid_cnt", {48'd0, bus.out_cnt}, 64'd1);
    tick();
    chk("rstmid_drained", {63'd0, bus.out_valid}, 64'd0);

    // Randomized end-to-end run against an exact-integer scoreboard
    begin
      logic signed [31:0]  x;
      logic signed [31:0]  y;
      logic signed [63:0]  prod;
      logic signed [127:0] run_sum;
      int run_cnt;
      int blk_len;
      int sent;
      int drained;
      int cycles;
      bit have_term;
      bit cur_last;
      bit full_m;
      bit accept;
      res_t r;

      run_sum = 128'sd0;
      run_cnt = 0;
      blk_len = 0;
      sent = 0;
      drained = 0;
      cycles = 0;
      have_term = 1'b0;
      cur_last = 1'b0;
      prod = 64'sd0;
      exp_q.delete();

      while (drained < NBLK && cycles < 60000) begin
        if (!have_term && sent < NBLK) begin
          if (run_cnt == 0) blk_len = $urandom_range(1, 8);
          x = ($urandom_range(0, 7) == 0) ? 32'sh8000_0000 : $signed($urandom);
          y = ($urandom_range(0, 7) == 0) ? 32'sh8000_0000 : $signed($urandom);
          prod = x * y;
          cur_last = (run_cnt + 1 == blk_len);
          have_term = 1'b1;
        end
        bus.p = prod;
        bus.p_last = cur_last;
        bus.p_valid = have_term && ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        #1;
        full_m = (exp_q.size() != 0);
        chk("rnd_valid", {63'd0, bus.out_valid}, {63'd0, full_m});
        chk("rnd_p_ready", {63'd0, bus.p_ready}, {63'd0, (!full_m || bus.out_ready)});
        if (full_m && bus.out_ready) begin
          r = exp_q.pop_front();
          chk("rnd_sum", bus.out_sum, r.sum);
          chk("rnd_cnt", {48'd0, bus.out_cnt}, {48'd0, r.cnt});
          chk("rnd_ovf", {63'd0, bus.out_ovf}, {63'd0, r.ovf});
          drained = drained + 1;
        end
        accept = bus.p_valid && (!full_m || bus.out_ready);
        if (accept) begin
          run_sum = run_sum + prod;
          run_cnt = run_cnt + 1;
          have_term = 1'b0;
          if (cur_last) begin
            exp_q.push_back(ref_result(run_sum, run_cnt));
            run_sum = 128'sd0;
            run_cnt = 0;
            sent = sent + 1;
          end
        end
        tick();
        cycles = cycles + 1;
      end
      chk("rnd_all_drained", 64'(drained), 64'(NBLK));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
